// File: rtl/ffd_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package ffd_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int DEF_OCC_W = clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/ffd_pipe_elastic_if.sv
// Producer/consumer handshake bundle for ffd_pipe_elastic.
interface ffd_pipe_elastic_if
  import ffd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] datos;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Q_out;

  modport master (output in_valid, datos, out_ready,
                  input  in_ready, out_valid, Q_out);
  modport slave  (input  in_valid, datos, out_ready,
                  output in_ready, out_valid, Q_out);
endinterface

// File: rtl/ffd_stage.sv
// One elastic slice: valid bit plus data register; data only captures valid words.
module ffd_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  output logic             vout,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vout <= 1'b0;
      dout <= RESET_VAL;
    end else if (clear) begin
      vout <= 1'b0;
      dout <= RESET_VAL;
    end else if (load) begin
      vout <= vin;
      // a bubble passing through leaves the last word visible
      if (vin) dout <= din;
    end
  end

endmodule

// File: rtl/ffd_pipe_elastic.sv
// DEPTH-stage valid/ready register pipeline with freeze, flush and bubble collapse.
// Optional FFD_PIPE_OCC_EN adds the occupancy (valid-stage count) port.
module ffd_pipe_elastic
  import ffd_pkg::*;
#(
  parameter int                WIDTH     = DEF_WIDTH,
  parameter int                DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int               OCC_W     = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  ffd_pipe_elastic_if.slave     bus
`ifdef FFD_PIPE_OCC_EN
  ,
  output logic [OCC_W-1:0]      occupancy
`endif
);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            adv;
  logic                        in_ready;
  logic                        accept;

  // Stage i may advance if downstream moves or stage i is a bubble.
  always_comb begin
    logic a;
    a = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      a      = a | ~v[i];
      adv[i] = a;
    end
  end

  assign in_ready      = reset & enable & ~clear & adv[0];
  assign accept        = bus.in_valid & in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = enable & v[DEPTH-1];
  assign bus.Q_out     = d[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             vin;
    logic [WIDTH-1:0] din;

    if (i == 0) begin : g_head
      assign vin = accept;
      assign din = bus.datos;
    end else begin : g_body
      assign vin = v[i-1];
      assign din = d[i-1];
    end

    ffd_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .load  (enable & adv[i]),
      .vin   (vin),
      .din   (din),
      .vout  (v[i]),
      .dout  (d[i])
    );
  end

`ifdef FFD_PIPE_OCC_EN
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(v[i]);
  end
`endif

endmodule

// File: tb/tb_ffd_pipe_elastic.sv
// Directed checks of ffd_pipe_elastic (WIDTH=8, DEPTH=3): reset, stream, backpressure,
// bubble collapse, freeze, clear and mid-stream reset.
module tb_ffd_pipe_elastic;
  import ffd_pkg::*;

  logic clk;
  logic reset;
  logic enable;
  logic clear;
  int   n_chk;
  int   n_err;

  ffd_pipe_elastic_if #(.WIDTH(8)) bus ();

`ifdef FFD_PIPE_OCC_EN
  logic [1:0] occupancy;
`endif

  ffd_pipe_elastic #(
    .WIDTH     (8),
    .DEPTH     (3),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .bus       (bus.slave)
`ifdef FFD_PIPE_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input int exp);
`ifdef FFD_PIPE_OCC_EN
    chk(tag, 32'(occupancy), 32'(exp));
`endif
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [7:0] q);
    chk({tag, ".ov"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".q"},  32'(bus.Q_out),     32'(q));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic vld, input logic [7:0] dat);
    bus.in_valid = vld;
    bus.datos    = dat;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    enable = 1'b0;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.datos     = 8'h00;
    bus.out_ready = 1'b0;

    // reset asserted mid-cycle, outputs settle without a clock edge
    #2 reset = 1'b0;
    #1;
    chk_out("rst", 1'b0, 8'h00);
    chk("rst.ir", 32'(bus.in_ready), 0);
    chk_occ("rst.occ", 0);
    enable = 1'b1;
    #1;
    chk("rst.ir_en", 32'(bus.in_ready), 0);
    step();
    reset = 1'b1;
    step();

    // stream
    bus.out_ready = 1'b1;
    offer(1'b1, 8'hF7);
    chk("st.ir", 32'(bus.in_ready), 1);
    step();
    offer(1'b1, 8'hF6);
    step();
    offer(1'b1, 8'h5A);
    step();
    offer(1'b0, 8'h00);
    chk_out("st.e3", 1'b1, 8'hF7);
    chk_occ("st.occ3", 3);
    step();
    chk_out("st.e4", 1'b1, 8'hF6);
    step();
    chk_out("st.e5", 1'b1, 8'h5A);
    chk_occ("st.occ5", 1);
    step();
    chk_out("st.e6", 1'b0, 8'h5A);
    chk_occ("st.occ6", 0);

    // backpressure
    bus.out_ready = 1'b0;
    offer(1'b1, 8'h31);
    step();
    offer(1'b1, 8'hF0);
    chk("bp.ir2", 32'(bus.in_ready), 1);
    step();
    offer(1'b1, 8'h5A);
    chk("bp.ir3", 32'(bus.in_ready), 1);
    step();
    offer(1'b1, 8'h33);
    chk("bp.ir4", 32'(bus.in_ready), 0);
    chk_occ("bp.occ", 3);
    chk_out("bp.full", 1'b1, 8'h31);
    step();
    chk_out("bp.hold", 1'b1, 8'h31);
    bus.out_ready = 1'b1;
    #1;
    chk("bp.ir_pp", 32'(bus.in_ready), 1);
    step();
    offer(1'b0, 8'h00);
    chk_out("bp.o2", 1'b1, 8'hF0);
    chk_occ("bp.occ_pp", 3);
    step();
    chk_out("bp.o3", 1'b1, 8'h5A);
    step();
    chk_out("bp.o4", 1'b1, 8'h33);
    step();
    chk_out("bp.end", 1'b0, 8'h33);

    // bubble collapse
    bus.out_ready = 1'b0;
    offer(1'b1, 8'h83);
    step();
    offer(1'b0, 8'h00);
    repeat (4) step();
    chk_out("bc.wait", 1'b1, 8'h83);
    chk_occ("bc.occ1", 1);
    offer(1'b1, 8'h88);
    chk("bc.ir88", 32'(bus.in_ready), 1);
    step();
    offer(1'b1, 8'h73);
    chk("bc.ir73", 32'(bus.in_ready), 1);
    chk_out("bc.s1", 1'b1, 8'h83);
    step();
    offer(1'b0, 8'h00);
    chk_out("bc.s2", 1'b1, 8'h83);
    chk_occ("bc.occ3", 3);
    bus.out_ready = 1'b1;
    step();
    chk_out("bc.o88", 1'b1, 8'h88);
    step();
    chk_out("bc.o73", 1'b1, 8'h73);
    step();
    chk_out("bc.end", 1'b0, 8'h73);

    // freeze
    bus.out_ready = 1'b0;
    offer(1'b1, 8'hA1);
    step();
    offer(1'b1, 8'hA2);
    step();
    offer(1'b0, 8'h00);
    step();
    chk_out("fr.pre", 1'b1, 8'hA1);
    enable = 1'b0;
    bus.out_ready = 1'b1;
    offer(1'b1, 8'hEE);
    chk_out("fr.off", 1'b0, 8'hA1);
    chk("fr.ir", 32'(bus.in_ready), 0);
    repeat (5) step();
    offer(1'b0, 8'h00);
    chk_out("fr.5", 1'b0, 8'hA1);
    chk_occ("fr.occ", 2);
    enable = 1'b1;
    #1;
    chk_out("fr.on", 1'b1, 8'hA1);
    step();
    chk_out("fr.next", 1'b1, 8'hA2);
    chk_occ("fr.occ1", 1);

    // clear with a word offered
    bus.out_ready = 1'b0;
    clear = 1'b1;
    offer(1'b1, 8'hD3);
    chk("cl.ir", 32'(bus.in_ready), 0);
    step();
    clear = 1'b0;
    offer(1'b0, 8'h00);
    chk_out("cl.after", 1'b0, 8'h00);
    chk_occ("cl.occ", 0);
    step();
    chk_out("cl.drop", 1'b0, 8'h00);

    // reset mid-stream
    bus.out_ready = 1'b0;
    offer(1'b1, 8'h11);
    step();
    offer(1'b1, 8'h22);
    step();
    step();
    offer(1'b0, 8'h00);
    chk_out("mr.pre", 1'b1, 8'h11);
    #2 reset = 1'b0;
    #1;
    chk_out("mr.rst", 1'b0, 8'h00);
    chk("mr.ir", 32'(bus.in_ready), 0);
    chk_occ("mr.occ", 0);
    step();
    reset = 1'b1;
    step();
    chk_out("mr.post", 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
